// File: rtl/regfile_scan_pkg.sv
// Shared definitions for the register file scan sequencer: sizes, command encodings and state enum.
package regfile_scan_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  localparam logic [1:0] OP_DUMP  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    HOLD,
    WR,
    FIN
  } state_t;

  // FILL pattern: seed plus the zero-extended register index, wrapping mod 2^DATA_W.
  function automatic logic [DATA_W-1:0] fillWord(input logic [DATA_W-1:0] seed,
                                                 input logic [ADDR_W-1:0] idx);
    return seed + DATA_W'(idx);
  endfunction

endpackage

// File: rtl/regfile_scan.sv
// Register file scan sequencer: CLEAR/FILL write r1..r31 one per cycle; DUMP streams r0..r31, one word per 2 cycles.
// Dump words hold stable while out_ready is low; commands are accepted only in IDLE and never queued.
module regfile_scan
  import regfile_scan_pkg::*;
(
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic [ADDR_W-1:0] rf_readReg,
  input  logic [DATA_W-1:0] rf_readData,
  output logic [ADDR_W-1:0] rf_writeReg,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              rf_regWrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] addrCnt;
  logic [1:0]        opReg;
  logic [DATA_W-1:0] seedReg;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addrCnt   <= '0;
      opReg     <= OP_DUMP;
      seedReg   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            opReg   <= cmd_op;
            seedReg <= cmd_seed;
            busy    <= 1'b1;
            case (cmd_op)
              OP_DUMP: begin
                addrCnt <= '0;
                state   <= RD;
              end
              OP_CLEAR, OP_FILL: begin
                addrCnt <= ADDR_W'(1);
                state   <= WR;
              end
              default: begin
                // Reserved op completes with no register traffic.
                state <= FIN;
                done  <= 1'b1;
              end
            endcase
          end
        end
        RD: begin
          out_data  <= rf_readData;
          out_addr  <= addrCnt;
          out_last  <= (addrCnt == LAST_REG);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              addrCnt <= addrCnt + ADDR_W'(1);
              state   <= RD;
            end
          end
        end
        WR: begin
          if (addrCnt == LAST_REG) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            addrCnt <= addrCnt + ADDR_W'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register-file side decodes straight from state so an async reset kills writes immediately.
  assign cmd_ready    = reset_n && (state == IDLE);
  assign rf_readReg   = (state == RD) ? addrCnt : '0;
  assign rf_regWrite  = (state == WR);
  assign rf_writeReg  = rf_regWrite ? addrCnt : '0;
  assign rf_writeData = (rf_regWrite && opReg == OP_FILL) ? fillWord(seedReg, addrCnt) : '0;

endmodule

// File: tb/tb_regfile_scan.sv
// Bench for regfile_scan: register file model on the rf_* ports, randomized commands and ready patterns,
// every dump word and write compared against an array model of the architectural registers.
module tb_regfile_scan;
  import regfile_scan_pkg::*;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_seed = '0;
  logic [4:0]  rf_readReg;
  logic [31:0] rf_readData;
  logic [4:0]  rf_writeReg;
  logic [31:0] rf_writeData;
  logic        rf_regWrite;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clock_in = ~clock_in;

  regfile_scan dut (
    .clock_in(clock_in), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_seed(cmd_seed),
    .rf_readReg(rf_readReg), .rf_readData(rf_readData), .rf_writeReg(rf_writeReg),
    .rf_writeData(rf_writeData), .rf_regWrite(rf_regWrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Register file model: r0 hardwired to zero, plus a bench-side poke port for preloading.
  logic [31:0] rfMem [32];
  logic        tbWe = 1'b0;
  logic [4:0]  tbAddr = '0;
  logic [31:0] tbData = '0;

  always @(posedge clock_in) begin
    if (tbWe) rfMem[tbAddr] <= tbData;
    else if (rf_regWrite && rf_writeReg != 5'd0) rfMem[rf_writeReg] <= rf_writeData;
  end
  assign rf_readData = (rf_readReg == 5'd0) ? 32'd0 : rfMem[rf_readReg];

  logic [31:0] refRegs [32];
  int vecCount  = 0;
  int missCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vecCount++;
    if (obs !== want) begin
      missCount++;
      $display("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic pokeReg(input int a, input logic [31:0] d);
    @(negedge clock_in);
    tbWe = 1'b1; tbAddr = 5'(a); tbData = d;
    refRegs[a] = d;
    @(posedge clock_in);
    #1 tbWe = 1'b0;
  endtask

  task automatic issueCmd(input logic [1:0] op, input logic [31:0] seed);
    @(negedge clock_in);
    checkVal("cmd_ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_seed = seed;
    @(posedge clock_in);
  endtask

  // Watches a CLEAR/FILL/reserved command from the accept edge; abortIdx > 0 pulses reset in that write cycle.
  task automatic watchWrite(input logic [1:0] op, input logic [31:0] seed, input int abortIdx);
    int nWr = 0, doneIdx = -1, nValid = 0, nDoneAfter = 0, lastGood = 31;
    bit aborted = 0;
    for (int idx = 1; idx <= 100; idx++) begin
      @(negedge clock_in);
      if (idx == 1) cmd_valid = 1'b0;
      if (out_valid) nValid++;
      if (rf_regWrite) begin
        nWr++;
        checkVal("wr_addr", rf_writeReg, idx);
        checkVal("wr_data", rf_writeData, (op == OP_FILL) ? seed + idx : 32'd0);
      end
      if (idx == abortIdx) begin
        #1 reset_n = 1'b0;
        #1;
        checkVal("abort_regWrite", rf_regWrite, 0);
        checkVal("abort_out_valid", out_valid, 0);
        checkVal("abort_busy", busy, 0);
        @(negedge clock_in);
        reset_n = 1'b1;
        #1 checkVal("abort_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 6; k++) begin
          @(negedge clock_in);
          if (done) nDoneAfter++;
        end
        checkVal("abort_no_done", nDoneAfter, 0);
        aborted  = 1;
        lastGood = abortIdx - 1;
        break;
      end
      if (done) begin
        doneIdx = idx;
        break;
      end
    end
    if (!aborted) begin
      checkVal("wr_count", nWr, (op == OP_RSVD) ? 0 : 31);
      checkVal("wr_done_cycle", doneIdx, (op == OP_RSVD) ? 1 : 32);
      checkVal("wr_no_out_valid", nValid, 0);
      @(negedge clock_in);
      checkVal("wr_done_width", done, 0);
    end
    if (op != OP_RSVD)
      for (int i = 1; i <= lastGood; i++)
        refRegs[i] = (op == OP_FILL) ? seed + i : 32'd0;
  endtask

  // mode 0: ready always high; 1: one cycle on, three off; 2: random ready.
  task automatic watchDump(input int mode, input bit holdFill, input logic [31:0] fillSeed);
    int nTx = 0, doneIdx = -1, firstValid = -1, phase = 0, nCollide = 0;
    bit prevStall = 0;
    logic [31:0] prevData = '0;
    logic [4:0]  prevAddr = '0;
    logic        prevLast = 1'b0;
    logic        rdy;
    for (int idx = 1; idx <= 600; idx++) begin
      @(negedge clock_in);
      if (idx == 1) begin
        if (holdFill) begin
          cmd_op = OP_FILL; cmd_seed = fillSeed;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (holdFill && cmd_ready) nCollide++;
      if (prevStall) begin
        checkVal("stall_valid", out_valid, 1);
        checkVal("stall_addr", out_addr, prevAddr);
        checkVal("stall_data", out_data, prevData);
        checkVal("stall_last", out_last, prevLast);
      end
      if (out_valid && firstValid < 0) firstValid = idx;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (phase == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase = (phase + 1) % 4;
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (nTx < 32) begin
          checkVal("dump_addr", out_addr, nTx);
          checkVal("dump_data", out_data, refRegs[nTx]);
          checkVal("dump_last", out_last, (nTx == 31));
        end
        nTx++;
      end
      prevStall = out_valid && !rdy;
      prevData = out_data; prevAddr = out_addr; prevLast = out_last;
      if (done) begin
        doneIdx = idx;
        break;
      end
    end
    checkVal("dump_transfers", nTx, 32);
    if (holdFill) checkVal("dump_cmd_ready_while_busy", nCollide, 0);
    if (mode == 0) begin
      checkVal("dump_first_valid", firstValid, 2);
      checkVal("dump_done_cycle", doneIdx, 65);
    end else begin
      checkVal("dump_done_seen", (doneIdx > 0), 1);
    end
    @(negedge clock_in);
    out_ready = 1'b0;
    checkVal("dump_done_width", done, 0);
    checkVal("dump_idle_ready", cmd_ready, 1);
    checkVal("dump_idle_busy", busy, 0);
  endtask

  initial begin
    logic [31:0] s;
    logic [1:0]  op;
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;

    #2;
    checkVal("rst_cmd_ready", cmd_ready, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_out_valid", out_valid, 0);
    checkVal("rst_out_data", out_data, 0);
    checkVal("rst_out_addr", out_addr, 0);
    checkVal("rst_out_last", out_last, 0);
    checkVal("rst_regWrite", rf_regWrite, 0);
    checkVal("rst_readReg", rf_readReg, 0);
    checkVal("rst_writeReg", rf_writeReg, 0);
    checkVal("rst_writeData", rf_writeData, 0);
    @(negedge clock_in);
    reset_n = 1'b1;
    #1 checkVal("rst_release_ready", cmd_ready, 1);

    for (int i = 1; i < 32; i++) pokeReg(i, $urandom);
    pokeReg(21, 32'hFAFA0C0C);
    issueCmd(OP_DUMP, 32'd0);  watchDump(2, 0, 32'd0);

    issueCmd(OP_CLEAR, $urandom); watchWrite(OP_CLEAR, 32'd0, 0);
    issueCmd(OP_DUMP, 32'd0);  watchDump(0, 0, 32'd0);

    issueCmd(OP_FILL, 32'hABCD0000); watchWrite(OP_FILL, 32'hABCD0000, 0);
    checkVal("fill_model_r10", refRegs[10], 32'hABCD000A);
    issueCmd(OP_DUMP, 32'd0);  watchDump(1, 0, 32'd0);

    // FILL held on cmd_valid throughout a dump must start exactly when the block returns to IDLE.
    s = $urandom;
    issueCmd(OP_DUMP, 32'd0);  watchDump(2, 1, s);
    @(posedge clock_in);
    watchWrite(OP_FILL, s, 0);
    issueCmd(OP_DUMP, 32'd0);  watchDump(2, 0, 32'd0);

    s = $urandom;
    issueCmd(OP_FILL, s);      watchWrite(OP_FILL, s, 15);
    issueCmd(OP_DUMP, 32'd0);  watchDump(0, 0, 32'd0);

    issueCmd(OP_RSVD, $urandom); watchWrite(OP_RSVD, 32'd0, 0);

    for (int n = 0; n < 5; n++) begin
      op = 2'($urandom_range(0, 2));
      s  = $urandom;
      issueCmd(op, s);
      if (op == OP_DUMP) watchDump(2, 0, 32'd0);
      else               watchWrite(op, s, 0);
    end
    issueCmd(OP_DUMP, 32'd0);  watchDump(2, 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
